// File: rtl/mux8_rr_sched.sv
// mux8_rr_sched: round-robin scheduler in front of an 8:1 mux.
// A granted channel holds select stable for HOLD cycles, then data[select]
// is captured into y and presented with a valid/ready handshake.
module mux8_rr_sched #(
    parameter int HOLD = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] req,
    input  logic [7:0] data,
    input  logic       y_ready,
    output logic [2:0] select,
    output logic [7:0] grant,
    output logic       y,
    output logic       y_valid
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_PRESENT = 2'd2
    } state_t;

    // Settle counter preload: HOLD-1 so capture happens HOLD edges after grant.
    localparam logic [3:0] CNT_LOAD = 4'(HOLD - 1);

    state_t     state_q,   state_d;
    logic [2:0] select_q,  select_d;
    logic [7:0] grant_q,   grant_d;
    logic       y_q,       y_d;
    logic       y_valid_q, y_valid_d;
    logic [3:0] cnt_q,     cnt_d;
    logic [2:0] ptr_q,     ptr_d;

    // Requests rotated so bit 0 is the channel right after the last served one.
    logic [7:0] rot_req;
    logic [2:0] pick_off;
    logic       pick_found;
    logic [2:0] pick_idx;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_rot
            assign rot_req[gi] = req[ptr_q + 3'(gi + 1)];
        end
    endgenerate

    // Lowest set bit of the rotated request vector wins.
    always_comb begin
        pick_off   = 3'd0;
        pick_found = 1'b0;
        for (int k = 7; k >= 0; k--) begin
            if (rot_req[k]) begin
                pick_off   = 3'(k);
                pick_found = 1'b1;
            end
        end
    end

    assign pick_idx = ptr_q + pick_off + 3'd1;

    // Next-state and registered-output logic for the three-phase transaction.
    always_comb begin
        state_d   = state_q;
        select_d  = select_q;
        grant_d   = grant_q;
        y_d       = y_q;
        y_valid_d = y_valid_q;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        case (state_q)
            ST_IDLE: begin
                grant_d = 8'h00;
                if (en && pick_found) begin
                    select_d = pick_idx;
                    grant_d  = 8'h01 << pick_idx;
                    cnt_d    = CNT_LOAD;
                    state_d  = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                // Committed: req/en are ignored until the transfer completes.
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    y_d       = data[select_q];
                    y_valid_d = 1'b1;
                    state_d   = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (y_ready) begin
                    y_valid_d = 1'b0;
                    grant_d   = 8'h00;
                    ptr_d     = select_q;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = 8'h00;
            end
        endcase
    end

    // State register; reset leaves ptr at 7 so the first search starts at 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            select_q  <= 3'd0;
            grant_q   <= 8'h00;
            y_q       <= 1'b0;
            y_valid_q <= 1'b0;
            cnt_q     <= 4'd0;
            ptr_q     <= 3'd7;
        end else begin
            state_q   <= state_d;
            select_q  <= select_d;
            grant_q   <= grant_d;
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
        end
    end

    assign select  = select_q;
    assign grant   = grant_q;
    assign y       = y_q;
    assign y_valid = y_valid_q;

endmodule

// File: tb/tb_mux8_rr_sched.sv
// Testbench for mux8_rr_sched: scenario tasks plus a transaction-level model.
module tb_mux8_rr_sched;

    localparam int HOLD = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [7:0] req = 8'h00;
    logic [7:0] data = 8'h00;
    logic       y_ready = 1'b0;
    logic [2:0] select, select1;
    logic [7:0] grant, grant1;
    logic       y, y1, y_valid, y_valid1;

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;

    mux8_rr_sched #(.HOLD(HOLD)) dut (
        .clk(clk), .rst(rst), .en(en), .req(req), .data(data), .y_ready(y_ready),
        .select(select), .grant(grant), .y(y), .y_valid(y_valid)
    );

    mux8_rr_sched #(.HOLD(1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .req(req), .data(data), .y_ready(y_ready),
        .select(select1), .grant(grant1), .y(y1), .y_valid(y_valid1)
    );

    always #5 clk = ~clk;

    // Reference model: busy flag + edges-since-grant age, arithmetic RR pick.
    logic       m_busy = 1'b0;
    int         m_age = 0;
    int         m_ptr = 7;
    logic [2:0] m_sel = 3'd0;
    logic [7:0] m_grant = 8'h00;
    logic       m_y = 1'b0;
    logic       m_valid = 1'b0;
    int         ch;

    function automatic int rr_pick(input int ptr, input logic [7:0] r);
        for (int k = 1; k <= 8; k++) begin
            if (r[(ptr + k) % 8]) return (ptr + k) % 8;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            m_busy <= 1'b0; m_age <= 0; m_ptr <= 7; m_sel <= 3'd0;
            m_grant <= 8'h00; m_y <= 1'b0; m_valid <= 1'b0;
        end else if (!m_busy) begin
            ch = rr_pick(m_ptr, req);
            if (en && ch >= 0) begin
                m_busy <= 1'b1; m_age <= 0; m_sel <= 3'(ch); m_grant <= 8'(1 << ch);
            end else begin
                m_grant <= 8'h00;
            end
        end else if (!m_valid) begin
            m_age <= m_age + 1;
            if (m_age + 1 == HOLD) begin
                m_y <= data[m_sel];
                m_valid <= 1'b1;
            end
        end else if (y_ready) begin
            m_valid <= 1'b0; m_grant <= 8'h00; m_ptr <= int'(m_sel); m_busy <= 1'b0;
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; req = 8'hFF; data = 8'hFF; y_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if ({select, grant, y_valid, y} !== {3'd0, 8'h00, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state got sel=%0d grant=%h v=%b y=%b want sel=0 grant=00 v=0 y=0",
                     select, grant, y_valid, y);
        end
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (grant !== 8'h01 || select !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_first_grant got sel=%0d grant=%h want sel=0 grant=01", select, grant);
        end
        $display("[TB] reset: first grant sel=%0d grant=%h", select, grant);
    endtask

    task automatic test_sweep();
        int order[9] = '{0, 1, 2, 3, 4, 5, 6, 7, 0};
        logic [7:0] dpat;
        logic [7:0] prev_g;
        logic prev_v;
        int n_g, n_v, last_g, last_v, t;
        dpat = 8'b10110110;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; en = 1'b1; req = 8'hFF; data = dpat; y_ready = 1'b1;
        prev_g = 8'h00; prev_v = 1'b0; n_g = 0; n_v = 0; last_g = 0; last_v = 0; t = 0;
        while (n_g < 9 && t < 60) begin
            @(negedge clk);
            t++;
            n_tests++;
            if ({select, grant, y, y_valid} !== {m_sel, m_grant, m_y, m_valid}) begin
                n_fail++;
                $display("FAIL sweep_model cyc=%0d got %0d/%h/%b/%b want %0d/%h/%b/%b",
                         cyc, select, grant, y, y_valid, m_sel, m_grant, m_y, m_valid);
            end
            if (grant !== 8'h00 && prev_g === 8'h00) begin
                n_tests++;
                if (int'(select) != order[n_g] || (n_g > 0 && cyc - last_g != HOLD + 2)) begin
                    n_fail++;
                    $display("FAIL sweep_grant n=%0d got ch=%0d gap=%0d want ch=%0d gap=%0d",
                             n_g, select, cyc - last_g, order[n_g], HOLD + 2);
                end
                $display("[TB] sweep grant #%0d ch=%0d cyc=%0d", n_g, select, cyc);
                last_g = cyc; n_g++;
            end
            if (y_valid === 1'b1 && prev_v === 1'b0) begin
                n_tests++;
                if (y !== dpat[select] || (n_v > 0 && cyc - last_v != HOLD + 2)) begin
                    n_fail++;
                    $display("FAIL sweep_y n=%0d got y=%b gap=%0d want y=%b gap=%0d",
                             n_v, y, cyc - last_v, dpat[select], HOLD + 2);
                end
                last_v = cyc; n_v++;
            end
            prev_g = grant; prev_v = y_valid;
        end
        n_tests++;
        if (n_g != 9) begin
            n_fail++;
            $display("FAIL sweep_timeout got %0d grants want 9", n_g);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] d0;
        logic exp_y;
        int t;
        do_reset();
        d0 = 8'($urandom);
        en = 1'b1; req = 8'h08; data = d0; y_ready = 1'b0;
        exp_y = d0[3];
        t = 0;
        while (y_valid !== 1'b1 && t < 10) begin @(negedge clk); t++; end
        n_tests++;
        if (t >= 10) begin n_fail++; $display("FAIL bp_timeout got v=%b want 1", y_valid); end
        for (int i = 0; i < 5; i++) begin
            data = ~data; req = 8'($urandom);
            @(negedge clk);
            n_tests++;
            if ({select, grant, y, y_valid} !== {3'd3, 8'h08, exp_y, 1'b1}) begin
                n_fail++;
                $display("FAIL bp_hold i=%0d got %0d/%h/%b/%b want 3/08/%b/1",
                         i, select, grant, y, y_valid, exp_y);
            end
        end
        y_ready = 1'b1; req = 8'h00;
        @(negedge clk);
        n_tests++;
        if ({grant, y_valid, y} !== {8'h00, 1'b0, exp_y}) begin
            n_fail++;
            $display("FAIL bp_transfer got grant=%h v=%b y=%b want 00/0/%b", grant, y_valid, y, exp_y);
        end
        $display("[TB] backpressure: y=%b released", y);
    endtask

    task automatic test_wrap();
        int t;
        do_reset();
        en = 1'b1; req = 8'h40; y_ready = 1'b1;
        t = 0;
        while (grant !== 8'h40 && t < 20) begin @(negedge clk); t++; end
        while (grant !== 8'h00 && t < 20) begin @(negedge clk); t++; end
        req = 8'b0100_0001;
        while (grant === 8'h00 && t < 20) begin @(negedge clk); t++; end
        n_tests++;
        if (grant !== 8'h01 || t >= 20) begin
            n_fail++;
            $display("FAIL wrap_first got grant=%h t=%0d want 01", grant, t);
        end
        while (grant !== 8'h00 && t < 30) begin @(negedge clk); t++; end
        while (grant === 8'h00 && t < 30) begin @(negedge clk); t++; end
        n_tests++;
        if (grant !== 8'h40 || t >= 30) begin
            n_fail++;
            $display("FAIL wrap_second got grant=%h t=%0d want 40", grant, t);
        end
        $display("[TB] wrap: second grant=%h", grant);
    endtask

    task automatic test_commit_abort();
        logic [7:0] d0;
        int t;
        do_reset();
        d0 = 8'($urandom);
        en = 1'b1; req = 8'h04; data = d0; y_ready = 1'b0;
        t = 0;
        while (grant === 8'h00 && t < 10) begin @(negedge clk); t++; end
        req = 8'h00; en = 1'b0;
        while (y_valid !== 1'b1 && t < 10) begin @(negedge clk); t++; end
        n_tests++;
        if ({y_valid, y, grant} !== {1'b1, d0[2], 8'h04}) begin
            n_fail++;
            $display("FAIL commit got v=%b y=%b grant=%h want 1/%b/04", y_valid, y, grant, d0[2]);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_tests++;
        if ({y_valid, grant, select} !== {1'b0, 8'h00, 3'd0}) begin
            n_fail++;
            $display("FAIL abort got v=%b grant=%h sel=%0d want 0/00/0", y_valid, grant, select);
        end
        $display("[TB] commit/abort: v=%b grant=%h", y_valid, grant);
    endtask

    task automatic test_enable();
        do_reset();
        en = 1'b0; req = 8'hFF; y_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_tests++;
            if (grant !== 8'h00) begin
                n_fail++;
                $display("FAIL enable_off i=%0d got grant=%h want 00", i, grant);
            end
        end
        en = 1'b1;
        @(negedge clk);
        n_tests++;
        if (grant !== 8'h01) begin
            n_fail++;
            $display("FAIL enable_on got grant=%h want 01", grant);
        end
        $display("[TB] enable: grant=%h after en", grant);
    endtask

    task automatic test_hold1();
        int k, t;
        logic [7:0] d0;
        do_reset();
        k = $urandom_range(0, 7);
        d0 = 8'($urandom);
        en = 1'b1; req = 8'(1 << k); data = d0; y_ready = 1'b0;
        t = 0;
        while (grant1 === 8'h00 && t < 10) begin @(negedge clk); t++; end
        n_tests++;
        if (grant1 !== 8'(1 << k) || y_valid1 !== 1'b0) begin
            n_fail++;
            $display("FAIL hold1_grant got grant=%h v=%b want %h/0", grant1, y_valid1, 8'(1 << k));
        end
        @(negedge clk);
        n_tests++;
        if (y_valid1 !== 1'b1 || y1 !== d0[k]) begin
            n_fail++;
            $display("FAIL hold1_latency got v=%b y=%b want 1/%b", y_valid1, y1, d0[k]);
        end
        $display("[TB] hold1: ch=%0d y=%b", k, y1);
    endtask

    task automatic test_random();
        int bad = 0;
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            en = ($urandom_range(0, 7) != 0);
            req = 8'($urandom);
            if ($urandom_range(0, 3) == 0) req = 8'(1 << $urandom_range(0, 7));
            if ($urandom_range(0, 7) == 0) req = 8'h00;
            data = 8'($urandom);
            y_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            n_tests++;
            if ({select, grant, y, y_valid} !== {m_sel, m_grant, m_y, m_valid}) begin
                n_fail++; bad++;
                if (bad < 10)
                    $display("FAIL random cyc=%0d got %0d/%h/%b/%b want %0d/%h/%b/%b",
                             cyc, select, grant, y, y_valid, m_sel, m_grant, m_y, m_valid);
            end
        end
        rst = 1'b0;
        $display("[TB] random: 1500 cycles, %0d deviations", bad);
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_backpressure();
        test_wrap();
        test_commit_abort();
        test_enable();
        test_hold1();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
